// File: rtl/common_pkg.sv
// Shared definitions for the sequential one-hot/multi-hot to binary encoder.
package common_pkg;

  // FSM state encoding. These are plain constants so older code can use them.
  localparam logic [0:0] ENC_ST_IDLE = 1'b0;
  localparam logic [0:0] ENC_ST_BUSY = 1'b1;

endpackage

// File: rtl/prio_enc_param.sv
// Combinational priority encoder. It reports the lowest set index,
// whether any bit is set, and whether exactly one bit is set.
module prio_enc_param #(
  parameter int BITS = 2,
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] i_vec,
  output logic [BITS-1:0] o_idx,
  output logic            o_any,
  output logic            o_one
);

  logic w_found;

  // Scan from bit 0 upward. The first set bit found gives the index.
  always_comb begin
    o_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      if (i_vec[i] && !w_found) begin
        o_idx   = BITS'(i);
        w_found = 1'b1;
      end
    end
  end

  // Exactly one bit is set when the vector is nonzero and clearing its
  // lowest set bit leaves nothing.
  always_comb begin
    o_any = |i_vec;
    o_one = o_any && ((i_vec & (i_vec - SIZE'(1))) == '0);
  end

endmodule

// File: rtl/encoder_param_seq.sv
// Sequential encoder. It captures a SIZE-bit vector and then emits the binary
// index of each set bit, lowest first, one index per output handshake.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on state and rst, never on in_valid.
// Once out_valid is high, out and out_last hold until out_ready accepts them.
module encoder_param_seq
  import common_pkg::*;
#(
  parameter int BITS = 2,
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in,
  output logic [BITS-1:0] out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            none,
  output logic [0:0]      o_dbg_state
);

  logic [0:0]      r_state;
  logic [SIZE-1:0] r_pend;
  logic [BITS-1:0] r_out;
  logic            r_out_valid;
  logic            r_out_last;
  logic            r_none;

  logic [BITS-1:0] w_in_idx;
  logic            w_in_any;
  logic            w_in_one;
  logic [SIZE-1:0] w_cur_mask;
  logic [SIZE-1:0] w_rem;
  logic [BITS-1:0] w_nxt_idx;
  logic            w_nxt_any;
  logic            w_nxt_one;

  // Load path: this encoder finds the first index of the incoming vector.
  prio_enc_param #(.BITS(BITS), .SIZE(SIZE)) u_enc_in (
    .i_vec (in),
    .o_idx (w_in_idx),
    .o_any (w_in_any),
    .o_one (w_in_one)
  );

  // Build a one-hot mask of the index now being presented, then take the
  // pending bits that remain once that index is consumed.
  always_comb begin
    w_cur_mask = '0;
    for (int i = 0; i < SIZE; i++) begin
      w_cur_mask[i] = (r_out == BITS'(i));
    end
    w_rem = r_pend & ~w_cur_mask;
  end

  // Next-index path: this encoder works on the remaining pending bits.
  prio_enc_param #(.BITS(BITS), .SIZE(SIZE)) u_enc_nxt (
    .i_vec (w_rem),
    .o_idx (w_nxt_idx),
    .o_any (w_nxt_any),
    .o_one (w_nxt_one)
  );

  // Ready to accept only in IDLE. It is held low while reset is asserted.
  always_comb begin
    in_ready = (r_state == ENC_ST_IDLE) && !rst;
  end

  // FSM, pending vector and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ENC_ST_IDLE;
      r_pend      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_none      <= 1'b0;
    end else begin
      r_none <= 1'b0;
      case (r_state)
        ENC_ST_IDLE: begin
          if (in_valid && in_ready) begin
            if (w_in_any) begin
              r_pend      <= in;
              r_out       <= w_in_idx;
              r_out_last  <= w_in_one;
              r_out_valid <= 1'b1;
              r_state     <= ENC_ST_BUSY;
            end else begin
              // An all-zero vector has no indices. Flag it and drop it.
              r_none <= 1'b1;
            end
          end
        end
        ENC_ST_BUSY: begin
          if (r_out_valid && out_ready) begin
            r_pend <= w_rem;
            if (w_nxt_any) begin
              r_out      <= w_nxt_idx;
              r_out_last <= w_nxt_one;
            end else begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_state     <= ENC_ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ENC_ST_IDLE;
        end
      endcase
    end
  end

  // Drive the output ports from their registers.
  always_comb begin
    out         = r_out;
    out_valid   = r_out_valid;
    out_last    = r_out_last;
    none        = r_none;
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_encoder_param_seq.sv
// Directed testbench for encoder_param_seq. It drives one instance with the
// default parameters and one with BITS=3, SIZE=8.
module tb_encoder_param_seq;

  logic       clk;
  logic       rst;

  // Default-parameter instance (BITS=2, SIZE=4)
  logic       a_in_valid;
  logic       a_in_ready;
  logic [3:0] a_in;
  logic [1:0] a_out;
  logic       a_out_valid;
  logic       a_out_ready;
  logic       a_out_last;
  logic       a_none;
  logic [0:0] a_dbg_state;

  // Wide instance (BITS=3, SIZE=8)
  logic       b_in_valid;
  logic       b_in_ready;
  logic [7:0] b_in;
  logic [2:0] b_out;
  logic       b_out_valid;
  logic       b_out_ready;
  logic       b_out_last;
  logic       b_none;
  logic [0:0] b_dbg_state;

  int n_checks;
  int n_fail;

  encoder_param_seq u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (a_in_valid),
    .in_ready    (a_in_ready),
    .in          (a_in),
    .out         (a_out),
    .out_valid   (a_out_valid),
    .out_ready   (a_out_ready),
    .out_last    (a_out_last),
    .none        (a_none),
    .o_dbg_state (a_dbg_state)
  );

  encoder_param_seq #(.BITS(3), .SIZE(8)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (b_in_valid),
    .in_ready    (b_in_ready),
    .in          (b_in),
    .out         (b_out),
    .out_valid   (b_out_valid),
    .out_ready   (b_out_ready),
    .out_last    (b_out_last),
    .none        (b_none),
    .o_dbg_state (b_dbg_state)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic v, input logic [1:0] o, input logic l);
    check({tag, "_valid"}, 32'(a_out_valid), 32'(v));
    if (v) begin
      check({tag, "_out"},  32'(a_out),      32'(o));
      check({tag, "_last"}, 32'(a_out_last), 32'(l));
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    a_in_valid  = 1'b0;
    a_in        = '0;
    a_out_ready = 1'b0;
    b_in_valid  = 1'b0;
    b_in        = '0;
    b_out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out",       32'(a_out),       32'd0);
    check("rst_out_last",  32'(a_out_last),  32'd0);
    check("rst_none",      32'(a_none),      32'd0);
    check("rst_in_ready",  32'(a_in_ready),  32'd0);
    check("rst_b_in_ready", 32'(b_in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(a_in_ready), 32'd1);
    check("rel_state",    32'(a_dbg_state), 32'd0);

    // Vector 1010 with out_ready high
    a_in = 4'b1010; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check_a("v1010_c1", 1'b1, 2'd1, 1'b0);
    check("v1010_busy", 32'(a_dbg_state), 32'd1);
    check("v1010_rdy_busy", 32'(a_in_ready), 32'd0);
    tick();
    check_a("v1010_c2", 1'b1, 2'd3, 1'b1);
    tick();
    check_a("v1010_c3", 1'b0, 2'd0, 1'b0);
    check("v1010_in_ready", 32'(a_in_ready), 32'd1);

    // Vector 1111 drains over four consecutive cycles
    a_in = 4'b1111; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check_a("v1111_i0", 1'b1, 2'd0, 1'b0);
    tick();
    check_a("v1111_i1", 1'b1, 2'd1, 1'b0);
    tick();
    check_a("v1111_i2", 1'b1, 2'd2, 1'b0);
    tick();
    check_a("v1111_i3", 1'b1, 2'd3, 1'b1);
    tick();
    check_a("v1111_end", 1'b0, 2'd0, 1'b0);

    // Vector 0111 with out_ready low for three cycles
    a_in = 4'b0111; a_in_valid = 1'b1; a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    check_a("v0111_hold0", 1'b1, 2'd0, 1'b0);
    tick();
    check_a("v0111_hold1", 1'b1, 2'd0, 1'b0);
    tick();
    check_a("v0111_hold2", 1'b1, 2'd0, 1'b0);
    a_out_ready = 1'b1;
    tick();
    check_a("v0111_i1", 1'b1, 2'd1, 1'b0);
    tick();
    check_a("v0111_i2", 1'b1, 2'd2, 1'b1);
    tick();
    check_a("v0111_end", 1'b0, 2'd0, 1'b0);

    // An all-zero vector pulses none for one cycle
    a_in = 4'b0000; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check("v0000_none",     32'(a_none),      32'd1);
    check("v0000_valid",    32'(a_out_valid), 32'd0);
    check("v0000_in_ready", 32'(a_in_ready),  32'd1);
    tick();
    check("v0000_none_off", 32'(a_none),      32'd0);
    check("v0000_valid2",   32'(a_out_valid), 32'd0);
    check("v0000_in_ready2", 32'(a_in_ready), 32'd1);

    // Vector 1100, then reset after the first index is accepted
    a_in = 4'b1100; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check_a("v1100_i2", 1'b1, 2'd2, 1'b0);
    tick();
    check_a("v1100_i3", 1'b1, 2'd3, 1'b1);
    rst = 1'b1;
    tick();
    check("midrst_valid",    32'(a_out_valid), 32'd0);
    check("midrst_out",      32'(a_out),       32'd0);
    check("midrst_last",     32'(a_out_last),  32'd0);
    check("midrst_in_ready", 32'(a_in_ready),  32'd0);
    rst = 1'b0;
    #1;
    check("midrst_rel_ready", 32'(a_in_ready), 32'd1);
    a_in = 4'b0001; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check_a("v0001_i0", 1'b1, 2'd0, 1'b1);
    tick();
    check_a("v0001_end", 1'b0, 2'd0, 1'b0);

    // Wide instance: a second vector offered while busy is not captured
    b_in = 8'h80; b_in_valid = 1'b1; b_out_ready = 1'b0;
    tick();
    b_in = 8'h01;
    check("b80_valid",    32'(b_out_valid), 32'd1);
    check("b80_out",      32'(b_out),       32'd7);
    check("b80_last",     32'(b_out_last),  32'd1);
    check("b80_in_ready", 32'(b_in_ready),  32'd0);
    tick();
    check("b80_hold_out",   32'(b_out),      32'd7);
    check("b80_hold_ready", 32'(b_in_ready), 32'd0);
    b_out_ready = 1'b1;
    tick();
    check("b80_done_valid", 32'(b_out_valid), 32'd0);
    check("b80_done_ready", 32'(b_in_ready),  32'd1);
    tick();
    b_in_valid = 1'b0;
    check("b01_valid", 32'(b_out_valid), 32'd1);
    check("b01_out",   32'(b_out),       32'd0);
    check("b01_last",  32'(b_out_last),  32'd1);
    tick();
    check("b01_end_valid", 32'(b_out_valid), 32'd0);
    check("b_none_quiet",  32'(b_none),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
